// File: rtl/ps2_rx_if.sv
// ps2_rx_if: key-event output bundle of the PS/2 receiver.
// The receiver drives it through the master modport; the consumer reads it through the slave modport.
interface ps2_rx_if;
   logic [7:0] code;
   logic       is_ext;
   logic       is_break;
   logic       code_valid;
   logic       frame_err;

   modport master (
      output code,
      output is_ext,
      output is_break,
      output code_valid,
      output frame_err
   );

   modport slave (
      input code,
      input is_ext,
      input is_break,
      input code_valid,
      input frame_err
   );
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with pin filtering, deframing and E0/F0 prefix folding.
// Optional define PS2_RX_PARITY_EN enforces odd parity; without it the parity bit is sampled but ignored.
module ps2_rx #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     PS2C,
   input  logic     PS2D,
   ps2_rx_if.master bus
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef PS2_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   // Odd parity: the data bits together with the parity bit must hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      odd_parity_ok = ^{data, par};
   endfunction

   logic                  ps2c_meta_r;
   logic                  ps2c_sync_r;
   logic                  ps2d_meta_r;
   logic                  ps2d_sync_r;
   logic [FILTER_LEN-1:0] ps2c_shift_r;
   logic [FILTER_LEN-1:0] ps2d_shift_r;
   logic                  ps2c_filt_r;
   logic                  ps2d_filt_r;
   logic                  fall_s;

   state_t                state_r;
   state_t                state_nxt_s;
   logic [2:0]            bit_cnt_r;
   logic [7:0]            data_r;
   logic                  par_bit_r;
   logic [TW-1:0]         tmo_cnt_r;
   logic                  timeout_s;
   logic                  par_ok_s;
   logic                  frame_ok_s;
   logic                  frame_bad_s;

   logic                  pend_ext_r;
   logic                  pend_brk_r;
   logic [7:0]            code_r;
   logic                  is_ext_r;
   logic                  is_break_r;
   logic                  code_valid_r;
   logic                  frame_err_r;

   // Two-flop synchronizers for both raw pins
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ps2c_meta_r <= 1'b1;
         ps2c_sync_r <= 1'b1;
         ps2d_meta_r <= 1'b1;
         ps2d_sync_r <= 1'b1;
      end else begin
         ps2c_meta_r <= PS2C;
         ps2c_sync_r <= ps2c_meta_r;
         ps2d_meta_r <= PS2D;
         ps2d_sync_r <= ps2d_meta_r;
      end
   end

   // Glitch filter: a filtered level only changes once the whole sample window agrees
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ps2c_shift_r <= {FILTER_LEN{1'b1}};
         ps2d_shift_r <= {FILTER_LEN{1'b1}};
         ps2c_filt_r  <= 1'b1;
         ps2d_filt_r  <= 1'b1;
      end else begin
         ps2c_shift_r <= {ps2c_shift_r[FILTER_LEN-2:0], ps2c_sync_r};
         ps2d_shift_r <= {ps2d_shift_r[FILTER_LEN-2:0], ps2d_sync_r};
         if (&ps2c_shift_r) begin
            ps2c_filt_r <= 1'b1;
         end else if (~|ps2c_shift_r) begin
            ps2c_filt_r <= 1'b0;
         end else begin
            ps2c_filt_r <= ps2c_filt_r;
         end
         if (&ps2d_shift_r) begin
            ps2d_filt_r <= 1'b1;
         end else if (~|ps2d_shift_r) begin
            ps2d_filt_r <= 1'b0;
         end else begin
            ps2d_filt_r <= ps2d_filt_r;
         end
      end
   end

   // High in the cycle the filtered clock is about to drop from 1 to 0
   assign fall_s    = ps2c_filt_r & ~(|ps2c_shift_r);
   assign timeout_s = (state_r != ST_IDLE) && (tmo_cnt_r == TW'(TIMEOUT_CYC));

   // Frame timeout counter: idle outside a frame, restarted by each clock fall
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmo_cnt_r <= {TW{1'b0}};
      end else if (timeout_s || (state_r == ST_IDLE) || fall_s) begin
         tmo_cnt_r <= {TW{1'b0}};
      end else if (tmo_cnt_r != TW'(TIMEOUT_CYC)) begin
         tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end

   // Deframer state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Deframer next state and frame verdict; a timeout wins over a simultaneous clock fall
   always_comb begin
      state_nxt_s = state_r;
      frame_ok_s  = 1'b0;
      frame_bad_s = 1'b0;
      par_ok_s    = !PAR_EN || odd_parity_ok(data_r, par_bit_r);
      if (timeout_s) begin
         state_nxt_s = ST_IDLE;
         frame_bad_s = 1'b1;
      end else if (fall_s) begin
         case (state_r)
            ST_IDLE: begin
               if (!ps2d_filt_r) begin
                  state_nxt_s = ST_DATA;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_DATA: begin
               if (bit_cnt_r == 3'd7) begin
                  state_nxt_s = ST_PARITY;
               end else begin
                  state_nxt_s = ST_DATA;
               end
            end
            ST_PARITY: begin
               state_nxt_s = ST_STOP;
            end
            ST_STOP: begin
               state_nxt_s = ST_IDLE;
               if (ps2d_filt_r && par_ok_s) begin
                  frame_ok_s = 1'b1;
               end else begin
                  frame_bad_s = 1'b1;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Data shifter, bit counter and parity capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_r    <= 8'h00;
         bit_cnt_r <= 3'd0;
         par_bit_r <= 1'b0;
      end else if (fall_s && !timeout_s) begin
         case (state_r)
            ST_IDLE: begin
               bit_cnt_r <= 3'd0;
            end
            ST_DATA: begin
               data_r    <= {ps2d_filt_r, data_r[7:1]};
               bit_cnt_r <= bit_cnt_r + 3'd1;
            end
            ST_PARITY: begin
               par_bit_r <= ps2d_filt_r;
            end
            default: begin
               bit_cnt_r <= bit_cnt_r;
            end
         endcase
      end
   end

   // Prefix folding and registered event outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_ext_r   <= 1'b0;
         pend_brk_r   <= 1'b0;
         code_r       <= 8'h00;
         is_ext_r     <= 1'b0;
         is_break_r   <= 1'b0;
         code_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         code_valid_r <= 1'b0;
         frame_err_r  <= frame_bad_s;
         if (frame_bad_s) begin
            pend_ext_r <= 1'b0;
            pend_brk_r <= 1'b0;
         end else if (frame_ok_s) begin
            if (data_r == 8'hE0) begin
               pend_ext_r <= 1'b1;
            end else if (data_r == 8'hF0) begin
               pend_brk_r <= 1'b1;
            end else begin
               code_r       <= data_r;
               is_ext_r     <= pend_ext_r;
               is_break_r   <= pend_brk_r;
               code_valid_r <= 1'b1;
               pend_ext_r   <= 1'b0;
               pend_brk_r   <= 1'b0;
            end
         end
      end
   end

   assign bus.code       = code_r;
   assign bus.is_ext     = is_ext_r;
   assign bus.is_break   = is_break_r;
   assign bus.code_valid = code_valid_r;
   assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed-frame bench for ps2_rx; frames are bit-banged on the pins and events are counted at negedge.
module tb_ps2_rx;
   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_CYC = 20000;

   logic clk;
   logic rst_n;
   logic ps2c;
   logic ps2d;
   ps2_rx_if rx_if ();

   int tests_run;
   int tests_failed;
   int valid_cnt;
   int err_cnt;
   int both_cnt;
   int v0;
   int e0;

   ps2_rx #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .PS2C (ps2c),
      .PS2D (ps2d),
      .bus  (rx_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe counters sampled away from the active edge
   always @(negedge clk) begin
      if (rx_if.code_valid) valid_cnt <= valid_cnt + 1;
      if (rx_if.frame_err) err_cnt <= err_cnt + 1;
      if (rx_if.code_valid && rx_if.frame_err) both_cnt <= both_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run = tests_run + 1;
      if (observed !== expected) begin
         tests_failed = tests_failed + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      ps2d = b;
      cycles(10);
      ps2c = 1'b0;
      cycles(20);
      ps2c = 1'b1;
      cycles(10);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic flip_par, input logic stop_bit);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(data[i]);
      send_bit((~^data) ^ flip_par);
      send_bit(stop_bit);
      ps2d = 1'b1;
      cycles(10);
   endtask

   task automatic mark;
      v0 = valid_cnt;
      e0 = err_cnt;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      valid_cnt    = 0;
      err_cnt      = 0;
      both_cnt     = 0;
      rst_n        = 1'b0;
      ps2c         = 1'b1;
      ps2d         = 1'b1;
      cycles(5);
      rst_n = 1'b1;
      cycles(20);
      check_eq("rst_code", {24'd0, rx_if.code}, 32'h0);
      check_eq("rst_flags", {29'd0, rx_if.is_ext, rx_if.is_break, rx_if.code_valid}, 32'h0);
      check_eq("rst_err", {31'd0, rx_if.frame_err}, 32'h0);

      // Plain make code
      mark();
      send_frame(8'h1C, 1'b0, 1'b1);
      check_eq("make_cnt", valid_cnt - v0, 32'd1);
      check_eq("make_code", {24'd0, rx_if.code}, 32'h1C);
      check_eq("make_flags", {30'd0, rx_if.is_ext, rx_if.is_break}, 32'h0);
      check_eq("make_err", err_cnt - e0, 32'd0);

      // Break prefix folds into the following code
      mark();
      send_frame(8'hF0, 1'b0, 1'b1);
      check_eq("f0_no_event", valid_cnt - v0, 32'd0);
      send_frame(8'h1C, 1'b0, 1'b1);
      check_eq("brk_cnt", valid_cnt - v0, 32'd1);
      check_eq("brk_code", {24'd0, rx_if.code}, 32'h1C);
      check_eq("brk_flags", {30'd0, rx_if.is_ext, rx_if.is_break}, 32'h1);

      // Extended break, then flags clear on the next make
      mark();
      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h75, 1'b0, 1'b1);
      check_eq("extbrk_cnt", valid_cnt - v0, 32'd1);
      check_eq("extbrk_code", {24'd0, rx_if.code}, 32'h75);
      check_eq("extbrk_flags", {30'd0, rx_if.is_ext, rx_if.is_break}, 32'h3);
      send_frame(8'h1C, 1'b0, 1'b1);
      check_eq("clr_code", {24'd0, rx_if.code}, 32'h1C);
      check_eq("clr_flags", {30'd0, rx_if.is_ext, rx_if.is_break}, 32'h0);

      // Wrong parity bit
      mark();
      send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_RX_PARITY_EN
      check_eq("par_err", err_cnt - e0, 32'd1);
      check_eq("par_valid", valid_cnt - v0, 32'd0);
`else
      check_eq("par_err", err_cnt - e0, 32'd0);
      check_eq("par_valid", valid_cnt - v0, 32'd1);
      check_eq("par_code", {24'd0, rx_if.code}, 32'h1C);
`endif

      // Bad stop bit
      mark();
      send_frame(8'h33, 1'b0, 1'b0);
      check_eq("stop_err", err_cnt - e0, 32'd1);
      check_eq("stop_valid", valid_cnt - v0, 32'd0);

      // Timeout after a partial frame, then recovery
      mark();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(i[0]);
      cycles(TIMEOUT_CYC + 10);
      check_eq("tmo_err", err_cnt - e0, 32'd1);
      check_eq("tmo_valid", valid_cnt - v0, 32'd0);
      send_frame(8'h2B, 1'b0, 1'b1);
      check_eq("tmo_next", {24'd0, rx_if.code}, 32'h2B);

      // Reset in the middle of a frame
      mark();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rst_n = 1'b0;
      cycles(2);
      rst_n = 1'b1;
      cycles(20);
      check_eq("midrst_strobes", (valid_cnt - v0) + (err_cnt - e0), 32'd0);
      check_eq("midrst_code", {24'd0, rx_if.code}, 32'h0);
      check_eq("midrst_flags", {29'd0, rx_if.is_ext, rx_if.is_break, rx_if.frame_err}, 32'h0);
      send_frame(8'h45, 1'b0, 1'b1);
      check_eq("midrst_next", {24'd0, rx_if.code}, 32'h45);

      // Short clock glitch with data low must not start a frame
      mark();
      ps2d = 1'b0;
      cycles(5);
      ps2c = 1'b0;
      cycles(3);
      ps2c = 1'b1;
      cycles(30);
      ps2d = 1'b1;
      cycles(10);
      send_frame(8'h1C, 1'b0, 1'b1);
      check_eq("glitch_cnt", valid_cnt - v0, 32'd1);
      check_eq("glitch_err", err_cnt - e0, 32'd0);
      check_eq("glitch_code", {24'd0, rx_if.code}, 32'h1C);

      check_eq("no_overlap", both_cnt, 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
